// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and register map for the serial receiver
package serial_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

   // Register select values, compared against addr[2]
   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   localparam int ST_NONEMPTY = 0;
   localparam int ST_OVR      = 1;
   localparam int ST_FERR     = 2;
   localparam int ST_COUNT    = 4;

endpackage

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - synchronous byte FIFO; a push at full is dropped unless a pop coincides
module serial_rx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    din,
   output logic [7:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver with receive FIFO and DATA/STATUS read registers
module serial_rx
   import serial_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   input  logic        sel,
   input  logic        re,
   input  logic [31:0] addr,
   output logic [31:0] dout,
   output logic        irq
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);

   logic          rx_m, rx_s, rx_p, start_edge;
   rx_state_e     state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic          push, ferr_set, pop, rd_status;
   logic          ovr, ferr, nonempty;
   logic [7:0]    fifo_head;
   logic [AW:0]   fifo_count;
   logic          fifo_full, fifo_empty;
   logic [31:0]   count_w;
   logic [3:0]    count_sat;
   logic          unused_addr;

   assign unused_addr = ^{addr[31:3], addr[1:0]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_p <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_p <= rx_s;
      end
   end

   // A held-low line gives no edge, so a break cannot retrigger the frame FSM
   assign start_edge = rx_p & ~rx_s;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt - 1'b1;
      bit_n    = bit_idx;
      shreg_n  = shreg;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = cnt;
            if (start_edge) begin
               state_n = START;
               cnt_n   = HALF_BIT;
            end
         end
         START: if (cnt == '0) begin
            if (!rx_s) begin
               state_n = DATA;
               cnt_n   = BIT_END;
               bit_n   = '0;
            end else begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         DATA: if (cnt == '0) begin
            shreg_n = {rx_s, shreg[7:1]};
            cnt_n   = BIT_END;
            bit_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
         end
         STOP: if (cnt == '0) begin
            state_n  = IDLE;
            cnt_n    = '0;
            push     = rx_s;
            ferr_set = ~rx_s;
         end
         default: state_n = IDLE;
      endcase
   end

   serial_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (shreg),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign nonempty  = ~fifo_empty;
   assign irq       = nonempty;
   assign pop       = sel & re & (addr[2] == REG_DATA) & nonempty;
   assign rd_status = sel & re & (addr[2] == REG_STATUS);
   assign count_w   = 32'(fifo_count);
   assign count_sat = (count_w > 32'd15) ? 4'hF : count_w[3:0];

   // Setting an error flag wins over a clearing STATUS read in the same cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         if (push && fifo_full && !pop) ovr <= 1'b1;
         else if (rd_status)            ovr <= 1'b0;
         if (ferr_set)       ferr <= 1'b1;
         else if (rd_status) ferr <= 1'b0;
      end
   end

   always_comb begin
      dout = '0;
      if (sel) begin
         if (addr[2] == REG_STATUS) begin
            dout[ST_NONEMPTY]     = nonempty;
            dout[ST_OVR]          = ovr;
            dout[ST_FERR]         = ferr;
            dout[ST_COUNT +: 4]   = count_sat;
         end else if (nonempty) begin
            dout[8:0] = {1'b1, fifo_head};
         end
      end
   end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed self-checking bench for serial_rx at DIV=16
`timescale 1ns/1ps
module tb_serial_rx;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx    = 1'b1;
   logic        sel   = 1'b0;
   logic        re    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] dout;
   logic        irq;
   int          checks = 0;
   int          errors = 0;

   serial_rx #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(16)) dut (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .sel   (sel),
      .re    (re),
      .addr  (addr),
      .dout  (dout),
      .irq   (irq)
   );

   always #5 clock = ~clock;

   // Frame driven on negedges, 16 clocks per bit, followed by two idle bit times
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clock); rx = frame[i];
         repeat (15) @(negedge clock);
      end
      @(negedge clock); rx = 1'b1;
      repeat (31) @(negedge clock);
   endtask

   task automatic send_timed(input logic [7:0] b, input int bit_ns);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         #(bit_ns);
      end
      rx = 1'b1;
      #(3 * bit_ns);
   endtask

   task automatic rd_reg(input logic [31:0] a, input logic strobe, output logic [31:0] d);
      @(negedge clock); sel = 1'b1; re = strobe; addr = a;
      #1 d = dout;
      @(posedge clock); #1 sel = 1'b0; re = 1'b0; addr = '0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h0); end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp %h", d, 32'h0); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
      @(negedge clock); reset = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_two_bytes();
      logic [31:0] d;
      send_byte(8'h55, 1'b1);
      rd_reg(32'h4, 1'b0, d);
      checks++; if (d !== 32'h11) begin errors++; $display("FAIL two_status1 got %h exp %h", d, 32'h11); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL two_irq1 got %b exp 1", irq); end
      @(negedge clock); sel = 1'b0; re = 1'b1; addr = 32'h0;
      #1 checks++; if (dout !== 32'h0) begin errors++; $display("FAIL two_nosel got %h exp %h", dout, 32'h0); end
      @(posedge clock); #1 re = 1'b0;
      send_byte(8'hA3, 1'b1);
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h21) begin errors++; $display("FAIL two_status2 got %h exp %h", d, 32'h21); end
      rd_reg(32'h0, 1'b0, d);
      checks++; if (d !== 32'h155) begin errors++; $display("FAIL two_peek got %h exp %h", d, 32'h155); end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h155) begin errors++; $display("FAIL two_data1 got %h exp %h", d, 32'h155); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL two_irq2 got %b exp 1", irq); end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h1A3) begin errors++; $display("FAIL two_data2 got %h exp %h", d, 32'h1A3); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL two_irq3 got %b exp 0", irq); end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL two_empty got %h exp %h", d, 32'h0); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i), 1'b1);
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'hF3) begin errors++; $display("FAIL ovf_status got %h exp %h", d, 32'hF3); end
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'hF1) begin errors++; $display("FAIL ovf_cleared got %h exp %h", d, 32'hF1); end
      for (int i = 0; i < 16; i++) begin
         rd_reg(32'h0, 1'b1, d);
         checks++; if (d !== (32'h110 + i)) begin errors++; $display("FAIL ovf_data%0d got %h exp %h", i, d, 32'h110 + i); end
      end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_empty got %h exp %h", d, 32'h0); end
   endtask

   task automatic test_framing();
      logic [31:0] d;
      send_byte(8'h7E, 1'b0);
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL ferr_status got %h exp %h", d, 32'h04); end
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h00) begin errors++; $display("FAIL ferr_cleared got %h exp %h", d, 32'h00); end
      @(negedge clock); rx = 1'b0;
      repeat (320) @(negedge clock);
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL break_ferr got %h exp %h", d, 32'h04); end
      repeat (320) @(negedge clock);
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h00) begin errors++; $display("FAIL break_once got %h exp %h", d, 32'h00); end
      @(negedge clock); rx = 1'b1;
      repeat (64) @(negedge clock);
      rd_reg(32'h4, 1'b0, d);
      checks++; if (d !== 32'h00) begin errors++; $display("FAIL break_after got %h exp %h", d, 32'h00); end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      @(negedge clock); rx = 1'b0;
      repeat (4) @(negedge clock);
      rx = 1'b1;
      repeat (40) @(negedge clock);
      rd_reg(32'h4, 1'b0, d);
      checks++; if (d !== 32'h00) begin errors++; $display("FAIL glitch_status got %h exp %h", d, 32'h00); end
      send_byte(8'h81, 1'b1);
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h181) begin errors++; $display("FAIL glitch_next got %h exp %h", d, 32'h181); end
   endtask

   task automatic test_full_pop();
      logic [31:0] d;
      logic [31:0] hit;
      logic [31:0] exp;
      for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b1);
      @(posedge clock); #1;
      fork
         send_byte(8'h80, 1'b1);
         begin
            // stop bit is sampled on the 155th rising edge after the start bit is driven
            repeat (154) @(posedge clock);
            @(negedge clock); sel = 1'b1; re = 1'b1; addr = 32'h0;
            #1 hit = dout;
            @(posedge clock); #1 sel = 1'b0; re = 1'b0;
         end
      join
      checks++; if (hit !== 32'h140) begin errors++; $display("FAIL full_pop_head got %h exp %h", hit, 32'h140); end
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'hF1) begin errors++; $display("FAIL full_pop_status got %h exp %h", d, 32'hF1); end
      for (int i = 0; i < 16; i++) begin
         exp = (i < 15) ? (32'h141 + i) : 32'h180;
         rd_reg(32'h0, 1'b1, d);
         checks++; if (d !== exp) begin errors++; $display("FAIL full_pop_data%0d got %h exp %h", i, d, exp); end
      end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL full_pop_empty got %h exp %h", d, 32'h0); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      send_byte(8'h99, 1'b1);
      @(posedge clock); #1;
      fork
         send_byte(8'hF0, 1'b1);
         begin
            repeat (89) @(posedge clock);
            #1 reset = 1'b1; sel = 1'b1; re = 1'b0; addr = 32'h4;
            #1 checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_mid_status got %h exp %h", dout, 32'h0); end
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b exp 0", irq); end
            addr = 32'h0;
            #1 checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h exp %h", dout, 32'h0); end
            sel = 1'b0;
            repeat (3) @(posedge clock);
            #1 reset = 1'b0;
         end
      join
      rd_reg(32'h4, 1'b0, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_flushed got %h exp %h", d, 32'h0); end
      send_byte(8'h3C, 1'b1);
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h13C) begin errors++; $display("FAIL rst_mid_next got %h exp %h", d, 32'h13C); end
      rd_reg(32'h0, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_empty got %h exp %h", d, 32'h0); end
   endtask

   task automatic test_tolerance();
      logic [31:0] d;
      logic [7:0]  bytes [3];
      int          rates [2];
      bytes = '{8'h00, 8'hFF, 8'h5A};
      rates = '{165, 155};
      #3;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++) send_timed(bytes[i], rates[r]);
      repeat (40) @(negedge clock);
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h61) begin errors++; $display("FAIL tol_status got %h exp %h", d, 32'h61); end
      for (int k = 0; k < 6; k++) begin
         rd_reg(32'h0, 1'b1, d);
         checks++; if (d !== {23'b0, 1'b1, bytes[k % 3]}) begin
            errors++; $display("FAIL tol_data%0d got %h exp %h", k, d, {23'b0, 1'b1, bytes[k % 3]});
         end
      end
      rd_reg(32'h4, 1'b1, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL tol_final got %h exp %h", d, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_two_bytes();
      test_overflow();
      test_framing();
      test_glitch();
      test_full_pop();
      test_reset_mid();
      test_tolerance();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
